// File: rtl/fetch_buffer_pkg.sv
// Shared types and constants for the instruction fetch buffer.
package fetch_buffer_pkg;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fb_state_e;

  // One buffered instruction together with its fall-through address.
  typedef struct packed {
    logic [WORD_W-1:0] inst;
    logic [WORD_W-1:0] pc4;
  } fb_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Entry storage and pointers for the fetch buffer; flush wins over push/pop.
module fetch_fifo
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  fb_entry_t              push_data,
  input  logic                   pop,
  input  logic                   flush,
  output fb_entry_t              head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  fb_entry_t     mem [DEPTH];

  // Pointer/count update and entry write; storage cleared so head reads 0 in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign level = count;
endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: issues sequential fetches, queues returned words,
// and flushes/refetches on branch redirect.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   mem_req,
  output logic [WORD_W-1:0]      mem_addr,
  input  logic                   mem_ack,
  input  logic [WORD_W-1:0]      mem_rdata,
  input  logic                   redirect,
  input  logic [WORD_W-1:0]      redirect_pc,
  input  logic                   hold,
  output logic                   inst_valid,
  output logic [WORD_W-1:0]      inst,
  output logic [WORD_W-1:0]      inst_pc4,
  output logic [$clog2(DEPTH):0] level
);
  localparam int LW = $clog2(DEPTH) + 1;

  fb_state_e         state, state_nxt;
  logic [WORD_W-1:0] fetch_pc;
  logic [WORD_W-1:0] held_addr;   // address still owed an ack while discarding
  logic              push, pop, full, empty, last_slot;
  fb_entry_t         head;

  // Redirect kills both the push of an arriving word and any pop this cycle.
  assign push      = (state == REQ) && mem_ack && !redirect;
  assign pop       = inst_valid && !hold && !redirect;
  assign last_slot = (level == LW'(DEPTH - 1)) && !pop;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ('{inst: mem_rdata, pc4: fetch_pc + 32'd4}),
    .pop       (pop),
    .flush     (redirect),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  assign inst_valid = !empty;
  assign inst       = head.inst;
  assign inst_pc4   = head.pc4;

  // State register, fetch pointer and the address held across a discard.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      held_addr <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (redirect)  fetch_pc <= redirect_pc;
      else if (push) fetch_pc <= fetch_pc + 32'd4;
      if (state == REQ && redirect && !mem_ack) held_addr <= fetch_pc;
    end
  end

  // Next state and memory-side outputs.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_addr  = fetch_pc;
    unique case (state)
      IDLE: begin
        // A pop or an empty slot guarantees room for the next word.
        if (redirect || pop || !full) state_nxt = REQ;
      end
      REQ: begin
        mem_req = 1'b1;
        if (redirect)                  state_nxt = mem_ack ? REQ : DISCARD;
        else if (mem_ack && last_slot) state_nxt = IDLE;
      end
      DISCARD: begin
        mem_req  = 1'b1;
        mem_addr = held_addr;
        if (mem_ack) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_fetch_buffer.sv
// Directed self-checking bench for fetch_buffer (DEPTH=4).
module tb_fetch_buffer;
  localparam logic [31:0] KEY = 32'hC0DE_0000;

  logic        clk, reset, mem_ack, redirect, hold;
  logic [31:0] redirect_pc, mem_rdata;
  logic        mem_req, inst_valid, mem_req2, inst_valid2;
  logic [31:0] mem_addr, inst, inst_pc4, mem_addr2, inst2, inst_pc42;
  logic [2:0]  level, level2;
  int          total = 0;
  int          bad = 0;

  // Memory returns a word tagged with its own address.
  assign mem_rdata = mem_addr ^ KEY;

  fetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .hold(hold), .inst_valid(inst_valid),
    .inst(inst), .inst_pc4(inst_pc4), .level(level)
  );

  fetch_buffer #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .reset(reset), .mem_req(mem_req2), .mem_addr(mem_addr2),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .hold(hold), .inst_valid(inst_valid2),
    .inst(inst2), .inst_pc4(inst_pc42), .level(level2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},   32'(mem_req), 32'd0);
    chk({tag, "_addr"},  mem_addr, 32'h0);
    chk({tag, "_level"}, 32'(level), 32'd0);
    chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_inst"},  inst, 32'h0);
    chk({tag, "_pc4"},   inst_pc4, 32'h0);
  endtask

  initial begin
    reset = 1'b1; mem_ack = 1'b1; hold = 1'b1; redirect = 1'b0; redirect_pc = '0;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("rst");
    chk("rst_addr2", mem_addr2, 32'hFFFF_FFF8);
    reset = 1'b1;

    // Zero-wait memory with hold: four back-to-back fetches then stop.
    @(negedge clk);
    chk("f0_req", 32'(mem_req), 32'd1);
    chk("f0_addr", mem_addr, 32'h0);
    chk("f0_addr2", mem_addr2, 32'hFFFF_FFF8);
    @(negedge clk);
    chk("f1_addr", mem_addr, 32'h4);
    chk("f1_level", 32'(level), 32'd1);
    chk("f1_valid", 32'(inst_valid), 32'd1);
    chk("f1_inst", inst, KEY);
    chk("f1_pc4", inst_pc4, 32'h4);
    chk("f1_addr2", mem_addr2, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("f2_addr", mem_addr, 32'h8);
    chk("f2_addr2", mem_addr2, 32'h0);
    chk("f2_pc42", inst_pc42, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("f3_addr", mem_addr, 32'hC);
    chk("f3_level", 32'(level), 32'd3);
    @(negedge clk);
    chk("full_level", 32'(level), 32'd4);
    chk("full_req", 32'(mem_req), 32'd0);
    chk("full_req2", 32'(mem_req2), 32'd0);

    // Held while full: head must not move.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_pc4", inst_pc4, 32'h4);
      chk("hold_level", 32'(level), 32'd4);
      chk("hold_req", 32'(mem_req), 32'd0);
    end
    hold = 1'b0;
    @(negedge clk);
    chk("rel_pc4", inst_pc4, 32'h8);
    chk("rel_level", 32'(level), 32'd3);
    chk("rel_req", 32'(mem_req), 32'd1);
    chk("rel_addr", mem_addr, 32'h10);
    chk("wrap_pc4", inst_pc42, 32'h0);
    @(negedge clk);
    chk("pp_pc4", inst_pc4, 32'hC);
    chk("pp_level", 32'(level), 32'd3);
    chk("pp_addr", mem_addr, 32'h14);
    @(negedge clk);
    chk("pp2_pc4", inst_pc4, 32'h10);
    chk("pp2_addr", mem_addr, 32'h18);
    hold = 1'b1; mem_ack = 1'b0;

    // Request pending without ack: address stable.
    @(negedge clk);
    chk("wait_level", 32'(level), 32'd3);
    chk("wait_addr", mem_addr, 32'h18);
    chk("wait_req", 32'(mem_req), 32'd1);
    @(negedge clk);
    chk("wait2_addr", mem_addr, 32'h18);

    // Asynchronous reset mid-request, checked before the next edge.
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk_reset("arst");
    @(negedge clk);
    reset = 1'b1; hold = 1'b0;

    // Delayed ack with redirect in the second wait cycle.
    @(negedge clk);
    chk("d_req", 32'(mem_req), 32'd1);
    chk("d_addr", mem_addr, 32'h0);
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect = 1'b0;
    chk("disc_req", 32'(mem_req), 32'd1);
    chk("disc_addr", mem_addr, 32'h0);
    chk("disc_level", 32'(level), 32'd0);
    mem_ack = 1'b1;
    @(negedge clk);
    chk("drop_level", 32'(level), 32'd0);
    chk("drop_valid", 32'(inst_valid), 32'd0);
    chk("drop_addr", mem_addr, 32'h100);
    @(negedge clk);
    chk("new_valid", 32'(inst_valid), 32'd1);
    chk("new_pc4", inst_pc4, 32'h104);
    chk("new_inst", inst, KEY ^ 32'h100);
    chk("new_addr", mem_addr, 32'h104);

    // Redirect coinciding with ack: word dropped.
    redirect = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    redirect = 1'b0;
    chk("ra_level", 32'(level), 32'd0);
    chk("ra_valid", 32'(inst_valid), 32'd0);
    chk("ra_addr", mem_addr, 32'h40);
    chk("ra_req", 32'(mem_req), 32'd1);
    @(negedge clk);
    chk("ra_pc4", inst_pc4, 32'h44);
    chk("ra_inst", inst, KEY ^ 32'h40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameter DEPTH, default 4: number of instruction entries; power of two, minimum 2.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 mem_req  output  1  fetch request to instruction memory.
REQ-006 mem_addr  output  32  byte address of the request.
REQ-007 mem_ack  input  1  memory accepts the request; mem_rdata is valid in the same cycle.
REQ-008 mem_rdata  input  32  instruction word returned on mem_ack.
REQ-009 redirect  input  1  taken branch from execute; flush and refetch.
REQ-010 redirect_pc  input  32  new fetch address, sampled when redirect=1.
REQ-011 hold  input  1  hazard stall from decode; the head entry is not consumed.
REQ-012 inst_valid  output  1  head entry is present.
REQ-013 inst  output  32  head instruction word.
REQ-014 inst_pc4  output  32  head instruction address plus 4.
REQ-015 level  output  $clog2(DEPTH)+1  current number of stored entries.

Function
REQ-016 The block SHALL hold a FIFO of {instruction, pc+4} entries; inst and inst_pc4 SHALL be driven combinationally from the head entry.
REQ-017 The controller SHALL have three states: IDLE (mem_req=0), REQ (mem_req=1, mem_addr=fetch_pc), and DISCARD (mem_req=1, mem_addr held, response dropped).
REQ-018 IDLE->REQ SHALL occur when level plus pending pops leaves at least one free slot; REQ->IDLE SHALL occur on mem_ack when the push fills the FIFO.
REQ-019 In REQ, mem_addr and mem_req SHALL remain stable until mem_ack.
REQ-020 On mem_ack in REQ, the block SHALL push {mem_rdata, fetch_pc+4} and set fetch_pc to fetch_pc+4.
REQ-021 If space remains after an ack, the block SHALL stay in REQ, giving one fetch per cycle with a zero-wait memory.
REQ-022 A pop SHALL occur when inst_valid=1 and hold=0.
REQ-023 Push and pop in the same cycle SHALL leave level unchanged and SHALL be legal at full and at one entry.
REQ-024 A request SHALL never be issued unless a slot is guaranteed free, so overflow cannot occur; pop on empty SHALL be impossible because inst_valid=0.
REQ-025 Latency: with the buffer empty and an ack in cycle N, inst_valid SHALL be 1 in cycle N+1.
REQ-026 redirect SHALL have priority over push, pop and hold in its cycle; it SHALL empty the FIFO (level=0 and inst_valid=0 next cycle) and load fetch_pc with redirect_pc.
REQ-027 redirect in REQ without mem_ack SHALL go to DISCARD; the old address SHALL be held until ack, the ack data dropped, and the state then SHALL move to REQ at redirect_pc.
REQ-028 redirect in the same cycle as mem_ack SHALL drop mem_rdata and go to REQ at redirect_pc next cycle.
REQ-029 redirect during DISCARD SHALL update fetch_pc only and SHALL stay in DISCARD.
REQ-030 fetch_pc+4 SHALL wrap modulo 2^32; mem_addr[1:0] SHALL equal fetch_pc[1:0] with no alignment check.

Reset
REQ-031 While reset=0: state=IDLE, fetch_pc=RESET_PC, FIFO pointers=0, level=0, inst_valid=0, mem_req=0, mem_addr=RESET_PC, inst=0, inst_pc4=0.
REQ-032 reset asserted mid-request SHALL abandon the outstanding request; the memory SHALL tolerate mem_req dropping without an ack.
REQ-033 The first mem_req SHALL rise in the first cycle after reset deasserts.

Structure
REQ-034 A shared package SHALL hold the state enum (IDLE, REQ, DISCARD) and the 32-bit word-width constant.
REQ-035 The FIFO storage and pointers SHALL be a separate sub-module, fetch_fifo (push, pop, flush, full, empty, level).

Verification
REQ-036 Reset release, RESET_PC=0, mem_ack tied to 1 -> mem_addr 0,4,8,12 on consecutive cycles; level reaches 4 and mem_req drops.
REQ-037 Buffer full, hold=1 for 5 cycles, then hold=0 -> inst_pc4 stays at 4 while held, then steps 4,8,12,16, and fetching resumes at address 16.
REQ-038 mem_ack delayed 3 cycles, redirect to 32'h100 in the 2nd wait cycle -> DISCARD; the ack data is dropped; the next mem_addr is 32'h100; the first inst_pc4 is 32'h104.
REQ-039 redirect to 32'h40 in the same cycle as mem_ack -> no push; level=0 next cycle; mem_addr=32'h40.
REQ-040 RESET_PC=32'hFFFF_FFF8 -> mem_addr FFFF_FFF8, FFFF_FFFC, 0000_0000; inst_pc4 of the second entry is 0.
REQ-041 reset asserted while in REQ with level=3 -> all outputs take their REQ-031 values asynchronously, before the next clock edge.
